// File: rtl/rst_seq_pkg.sv
// Shared state encoding, default parameters and helpers for the reset sequencer.
package rst_seq_pkg;

   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_STRETCH_CYCLES = 4;
   localparam int DEF_NUM_OUTPUTS    = 3;
   localparam int DEF_STAGGER_CYCLES = 2;

   typedef enum logic [2:0] {
      ST_ASSERT  = 3'd0,
      ST_SYNC    = 3'd1,
      ST_STRETCH = 3'd2,
      ST_RELEASE = 3'd3,
      ST_IDLE    = 3'd4
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sync.sv
// N-stage reset synchroniser: every stage is set asynchronously, and q releases synchronously.
module reset_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic async_reset_in,
   output logic q
);

   logic [N-1:0] chain;

   always_ff @(posedge clk or posedge async_reset_in) begin
      if (async_reset_in) begin
         chain <= '1;
      end else begin
         chain <= {chain[N-2:0], 1'b0};
      end
   end

   assign q = chain[N-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: async assert, synchronised release, stretch, then staggered per-domain release.
// Optional synchronous soft reset from IDLE is built when RSTSEQ_SOFT_RESET_EN is defined.
module reset_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
   parameter int NUM_OUTPUTS    = DEF_NUM_OUTPUTS,
   parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
   input  logic                   clk,
   input  logic                   async_reset_in,
`ifdef RSTSEQ_SOFT_RESET_EN
   input  logic                   soft_reset_req,
`endif
   output logic [NUM_OUTPUTS-1:0] reset_out,
   output logic                   reset_busy,
   output state_e                 fsm_state
);

   localparam int CNT_W = $clog2(max_int(STRETCH_CYCLES, STAGGER_CYCLES) + 1);
   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [NUM_OUTPUTS-1:0] LAST_ONE = NUM_OUTPUTS'(1) << (NUM_OUTPUTS - 1);

   logic             sync_q;
   state_e           state;
   logic [CNT_W-1:0] cnt;

   reset_sync #(.N(SYNC_STAGES)) u_sync (
      .clk            (clk),
      .async_reset_in (async_reset_in),
      .q              (sync_q)
   );

   // reset_out is a thermometer code: shifting left clears the lowest still-set domain,
   // so domains can only release in ascending order and never re-assert by themselves.
   // The edge that first sees sync_q low already counts as the first stretch edge, which
   // makes the net release land on edge SYNC_STAGES+STRETCH_CYCLES.
   always_ff @(posedge clk or posedge async_reset_in) begin
      if (async_reset_in) begin
         state     <= ST_ASSERT;
         cnt       <= '0;
         reset_out <= '1;
      end else begin
         unique case (state)
            ST_ASSERT: begin
               state <= ST_SYNC;
            end
            ST_SYNC, ST_STRETCH: begin
               if (state == ST_STRETCH || !sync_q) begin
                  if (cnt == STRETCH_LAST) begin
                     reset_out <= reset_out << 1;
                     cnt       <= '0;
                     state     <= (reset_out == LAST_ONE) ? ST_IDLE : ST_RELEASE;
                  end else begin
                     cnt   <= cnt + CNT_ONE;
                     state <= ST_STRETCH;
                  end
               end
            end
            ST_RELEASE: begin
               if (cnt == STAGGER_LAST) begin
                  reset_out <= reset_out << 1;
                  cnt       <= '0;
                  if (reset_out == LAST_ONE) begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            ST_IDLE: begin
`ifdef RSTSEQ_SOFT_RESET_EN
               if (soft_reset_req) begin
                  reset_out <= '1;
                  cnt       <= '0;
                  state     <= ST_STRETCH;
               end
`endif
            end
            default: begin
               reset_out <= '1;
               cnt       <= '0;
               state     <= ST_ASSERT;
            end
         endcase
      end
   end

   assign reset_busy = |reset_out;
   assign fsm_state  = state;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl: default instance plus a NUM_OUTPUTS=1, STRETCH_CYCLES=1 instance.
// Soft-reset scenarios are compiled when RSTSEQ_SOFT_RESET_EN is defined.
module tb_reset_seq_ctrl;
   import rst_seq_pkg::*;

   localparam int S  = 2;
   localparam int T  = 4;
   localparam int N  = 3;
   localparam int G  = 2;
   localparam int T1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         async_reset_in;
   logic         soft_reset_req;
   logic [N-1:0] reset_out;
   logic         reset_busy;
   state_e       fsm_state;
   logic [0:0]   reset_out1;
   logic         reset_busy1;
   state_e       fsm_state1;

   // bit N holds the single-domain instance, bits N-1:0 the default instance
   logic [N:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   reset_seq_ctrl dut (
      .clk            (clk),
      .async_reset_in (async_reset_in),
`ifdef RSTSEQ_SOFT_RESET_EN
      .soft_reset_req (soft_reset_req),
`endif
      .reset_out      (reset_out),
      .reset_busy     (reset_busy),
      .fsm_state      (fsm_state)
   );

   reset_seq_ctrl #(.NUM_OUTPUTS(1), .STRETCH_CYCLES(T1)) dut1 (
      .clk            (clk),
      .async_reset_in (async_reset_in),
`ifdef RSTSEQ_SOFT_RESET_EN
      .soft_reset_req (1'b0),
`endif
      .reset_out      (reset_out1),
      .reset_busy     (reset_busy1),
      .fsm_state      (fsm_state1)
   );

   // Release model: domain i of the default instance is low from edge base0+i*G on,
   // the single-domain instance from edge base1 on.
   function automatic logic [N:0] exp_vec(input int e, input int base0, input int base1);
      logic [N:0] v;
      for (int i = 0; i < N; i++) v[i] = (e < base0 + i * G);
      v[N] = (e < base1);
      return v;
   endfunction

   task automatic push_seq(input int first, input int last, input int base0, input int base1);
      for (int e = first; e <= last; e++) exp_q.push_back(exp_vec(e, base0, base1));
   endtask

   task automatic check_edges(input int n, input string name);
      logic [N:0] exp;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty at edge %0d, got %b required an entry", name, k, {reset_out1, reset_out});
         end else begin
            exp = exp_q.pop_front();
            if ({reset_out1, reset_out} !== exp) begin
               n_fail++;
               $display("FAIL %s edge %0d: reset_outs got %b required %b", name, k, {reset_out1, reset_out}, exp);
            end
            n_checks++;
            if ({reset_busy1, reset_busy} !== {exp[N], |exp[N-1:0]}) begin
               n_fail++;
               $display("FAIL %s edge %0d busy: got %b required %b", name, k, {reset_busy1, reset_busy}, {exp[N], |exp[N-1:0]});
            end
         end
      end
   endtask

   task automatic check_state(input state_e e0, input state_e e1, input string name);
      n_checks++;
      if (fsm_state !== e0 || fsm_state1 !== e1) begin
         n_fail++;
         $display("FAIL %s state: got %0d/%0d required %0d/%0d", name, fsm_state, fsm_state1, e0, e1);
      end
   endtask

   task automatic check_all_set(input string name);
      n_checks++;
      if ({reset_out1, reset_out} !== '1 || reset_busy !== 1'b1 || reset_busy1 !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: outputs got %b busy %b%b required all ones", name, {reset_out1, reset_out}, reset_busy1, reset_busy);
      end
   endtask

   task automatic test_reset();
      async_reset_in = 1'b1;
      soft_reset_req = 1'b0;
      #1;
      check_all_set("reset_immediate");
      check_state(ST_ASSERT, ST_ASSERT, "reset_immediate");
      for (int k = 0; k < 3; k++) exp_q.push_back('1);
      check_edges(3, "reset_hold");
      check_state(ST_ASSERT, ST_ASSERT, "reset_hold");
   endtask

   task automatic test_power_up();
      #1 async_reset_in = 1'b0;
      push_seq(1, 12, S + T, S + T1);
      check_edges(12, "power_up");
      check_state(ST_IDLE, ST_IDLE, "power_up_end");
   endtask

   task automatic test_glitch();
      #2 async_reset_in = 1'b1;
      #1 check_all_set("glitch_during");
      check_state(ST_ASSERT, ST_ASSERT, "glitch_during");
      #2 async_reset_in = 1'b0;
      #1 check_all_set("glitch_after");
      push_seq(1, 12, S + T, S + T1);
      check_edges(12, "glitch_seq");
      check_state(ST_IDLE, ST_IDLE, "glitch_end");
   endtask

   task automatic test_mid_reassert();
      async_reset_in = 1'b1;
      #1 async_reset_in = 1'b0;
      push_seq(1, 7, S + T, S + T1);
      check_edges(7, "mid_first");
      #1 async_reset_in = 1'b1;
      #1 check_all_set("mid_reassert");
      check_state(ST_ASSERT, ST_ASSERT, "mid_reassert");
      #1 async_reset_in = 1'b0;
      push_seq(1, 12, S + T, S + T1);
      check_edges(12, "mid_restart");
      check_state(ST_IDLE, ST_IDLE, "mid_end");
   endtask

`ifdef RSTSEQ_SOFT_RESET_EN
   task automatic test_soft_idle();
      #1 soft_reset_req = 1'b1;
      push_seq(0, 9, T, 0);
      check_edges(1, "soft_take");
      soft_reset_req = 1'b0;
      check_state(ST_STRETCH, ST_IDLE, "soft_take");
      check_edges(9, "soft_seq");
      check_state(ST_IDLE, ST_IDLE, "soft_end");
   endtask

   task automatic test_soft_in_release();
      async_reset_in = 1'b1;
      #1 async_reset_in = 1'b0;
      push_seq(1, 12, S + T, S + T1);
      check_edges(7, "soft_rel_pre");
      check_state(ST_RELEASE, ST_IDLE, "soft_rel_pre");
      soft_reset_req = 1'b1;
      check_edges(1, "soft_rel_ignored");
      soft_reset_req = 1'b0;
      check_edges(4, "soft_rel_post");
      check_state(ST_IDLE, ST_IDLE, "soft_rel_end");
   endtask

   task automatic test_soft_with_async();
      async_reset_in = 1'b1;
      soft_reset_req = 1'b1;
      for (int k = 0; k < 2; k++) exp_q.push_back('1);
      check_edges(2, "both_hold");
      check_state(ST_ASSERT, ST_ASSERT, "both_hold");
      #1 async_reset_in = 1'b0;
      push_seq(1, 12, S + T, S + T1);
      check_edges(4, "both_seq_a");
      soft_reset_req = 1'b0;
      check_edges(8, "both_seq_b");
      check_state(ST_IDLE, ST_IDLE, "both_end");
   endtask
`endif

   initial begin
      test_reset();
      test_power_up();
      test_glitch();
      test_mid_reassert();
`ifdef RSTSEQ_SOFT_RESET_EN
      test_soft_idle();
      test_soft_in_release();
      test_soft_with_async();
`endif
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reset_seq_ctrl.md
RESET_SEQ_CTRL -- requirements
Module: reset_seq_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth, legal range >= 2.
REQ-002 Parameter STRETCH_CYCLES, default 4: cycles all outputs stay in reset after synchronisation, legal range >= 1.
REQ-003 Parameter NUM_OUTPUTS, default 3: number of reset domains, legal range >= 1.
REQ-004 Parameter STAGGER_CYCLES, default 2: cycles between successive domain releases, legal range >= 1.
REQ-005 Port clk, input, 1 bit: the single clock; all sequential logic is on its rising edge.
REQ-006 Port async_reset_in, input, 1 bit: asynchronous, active-high reset; a level, a glitch or a rising edge all trigger a reset.
REQ-007 Port reset_out, output, NUM_OUTPUTS bits: active-high reset per domain; asserts asynchronously and releases synchronously.
REQ-008 Port reset_busy, output, 1 bit: high while any reset_out bit is high.
REQ-009 Port soft_reset_req, input, 1 bit: synchronous request for a full reset sequence; the port exists only under RSTSEQ_SOFT_RESET_EN.

Function
REQ-010 The FSM SHALL have states ASSERT, SYNC, STRETCH, RELEASE and IDLE.
REQ-011 While async_reset_in=1, the block SHALL force state=ASSERT, set all reset_out bits to 1 and clear all counters, asynchronously and without waiting for clk.
REQ-012 After async_reset_in falls, the state SHALL be SYNC until SYNC_STAGES rising edges have passed, then STRETCH.
REQ-013 STRETCH SHALL last STRETCH_CYCLES edges, then the FSM SHALL clear reset_out[0] and enter RELEASE.
REQ-014 In RELEASE, the block SHALL clear reset_out[i] exactly STAGGER_CYCLES edges after reset_out[i-1], in ascending index order.
REQ-015 The block SHALL enter IDLE on the edge that clears reset_out[NUM_OUTPUTS-1].
REQ-016 Net timing: after async_reset_in falls, reset_out[i] SHALL clear on rising edge SYNC_STAGES+STRETCH_CYCLES+i*STAGGER_CYCLES.
REQ-017 The block SHALL never release reset_out[j] for j>i while reset_out[i]=1.
REQ-018 The block SHALL never return a cleared bit to 1 except through ASSERT or a soft reset.
REQ-019 A pulse on async_reset_in narrower than one clk period SHALL still produce the complete sequence of REQ-016.
REQ-020 If async_reset_in re-asserts in any state (mid-sequence included), the block SHALL re-assert all outputs immediately and restart the sequence from ASSERT.
REQ-021 Counter widths SHALL be $clog2(max(STRETCH_CYCLES,STAGGER_CYCLES)+1) bits.
REQ-022 Counters SHALL never wrap; the stretch count and the stagger count each terminate exactly at their limit.

Reset
REQ-023 During reset: reset_out = all ones, reset_busy = 1, state = ASSERT, all counters = 0.
REQ-024 Every synchroniser flop SHALL be asynchronously set to 1 by async_reset_in.
REQ-025 No other flop SHALL use a synchronous reset.

Configuration
REQ-026 With RSTSEQ_SOFT_RESET_EN defined, soft_reset_req=1 sampled on an edge while in IDLE SHALL set all reset_out to 1 after that edge and enter STRETCH, bypassing SYNC.
REQ-027 With RSTSEQ_SOFT_RESET_EN defined, soft_reset_req SHALL be ignored in every state other than IDLE.
REQ-028 With RSTSEQ_SOFT_RESET_EN defined, when soft_reset_req and async_reset_in are both asserted, async_reset_in SHALL win.
REQ-029 Without RSTSEQ_SOFT_RESET_EN, the soft_reset_req port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-030 Package rst_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-031 Sub-module reset_sync SHALL be an N-stage async-set, sync-release synchroniser with ports clk, async_reset_in, q, instanced once with N=SYNC_STAGES.

Verification (SYNC_STAGES=2, STRETCH_CYCLES=4, NUM_OUTPUTS=3, STAGGER_CYCLES=2 unless stated)
REQ-032 Power-up with async_reset_in=1 for 3 cycles, then 0 -> reset_out=3'b111 throughout; bit0 clears on edge 6, bit1 on edge 8, bit2 on edge 10; reset_busy falls on edge 10.
REQ-033 From IDLE, a 0.3-period async_reset_in glitch between edges -> reset_out=3'b111 immediately; the release timing of REQ-032 is measured from the glitch.
REQ-034 Re-assert async_reset_in just after edge 7 (bit0 already clear) -> reset_out=3'b111 at once; the full sequence of REQ-032 restarts.
REQ-035 With the macro defined, soft_reset_req=1 at edge k in IDLE -> reset_out=3'b111 after edge k; bit0 clears at k+4, bit1 at k+6, bit2 at k+8.
REQ-036 With the macro defined, soft_reset_req=1 during RELEASE -> no effect; in a separate run, soft_reset_req and async_reset_in asserted together -> the async sequence runs.
REQ-037 With NUM_OUTPUTS=1 and STRETCH_CYCLES=1 -> reset_out[0] clears on edge 3 after async_reset_in falls.
